// File: rtl/exmem_skid_stage.sv
// ---------------------------------------------------------------------------
// exmem_skid_stage
//
// EX -> MEM pipeline register built as a two-entry skid buffer. HEAD drives
// the MEM-side outputs; SKID catches the one extra entry that may arrive in
// the cycle MEM stalls. Because in_ready is decoded from the state register
// alone, there is no combinational path from out_ready to in_ready, so a stall
// from MEM is cut at this stage instead of rippling back through EX.
//
// Parameters
//   DATA_W  width of ALU result / address and of store data
//   REG_AW  destination register index width
//   CTRL_W  control bundle width:
//           bit0 RegWrite, bit1 MemWrite, bit2 MemRead, bit3 mem_to_reg,
//           bit4 mem_src, bits above 4 user-defined (carried unchanged)
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   flush         synchronous kill of all held entries (beats accept and pop)
//   in_valid      EX presents an entry
//   in_ready      stage can take an entry this cycle (state != FULL)
//   ctrl_in       control bundle from EX
//   dest_reg_in   destination register from EX
//   ex_in         ALU result / memory address from EX
//   wdata_in      store data from EX
//   out_valid     HEAD holds an entry for MEM (state != EMPTY)
//   out_ready     MEM consumes the HEAD entry this cycle
//   ctrl_out      HEAD control bundle, forced to zero for bubbles
//   dest_reg_out  HEAD destination register (held while empty)
//   mem_addr      HEAD ALU result / address (held while empty)
//   wdata_out     HEAD store data (held while empty)
//   occupancy     number of held entries, 0..2
// ---------------------------------------------------------------------------
module exmem_skid_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [REG_AW-1:0] dest_reg_in,
  input  logic [DATA_W-1:0] ex_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [REG_AW-1:0] dest_reg_out,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] wdata_out,
  output logic [1:0]        occupancy
);

  // One pipeline entry as it travels from EX to MEM.
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [REG_AW-1:0] dest_reg;
    logic [DATA_W-1:0] ex;
    logic [DATA_W-1:0] wdata;
  } payload_t;

  // Encoding equals the entry count, so occupancy is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t   state;
  payload_t head_q;
  payload_t skid_q;
  payload_t in_payload;
  logic     accept;
  logic     pop;

  assign in_payload = {ctrl_in, dest_reg_in, ex_in, wdata_in};

  // Handshake flags depend only on the state register; accept and pop are
  // then qualified with the partner's valid/ready for the same edge.
  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign occupancy = state;

  // A bubble must never carry RegWrite/MemWrite/MemRead into MEM, so the
  // control bundle is gated; the data fields are left as they were.
  assign ctrl_out     = out_valid ? head_q.ctrl : '0;
  assign dest_reg_out = head_q.dest_reg;
  assign mem_addr     = head_q.ex;
  assign wdata_out    = head_q.wdata;

  // NOTE: every register here uses non-blocking assignment so all state,
  // HEAD and SKID update together from the values seen before the edge;
  // blocking assignment would let HEAD see a SKID value written this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the payload registers are reset as well as the state, because
      // the held HEAD fields are visible on mem_addr/wdata_out/dest_reg_out
      // while the stage is empty and must read zero straight after reset.
      state  <= ST_EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      // Kill everything, including an entry offered this cycle. HEAD keeps
      // its contents so the data outputs stay stable; ctrl_out is gated.
      state <= ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (accept) begin
            head_q <= in_payload;
            state  <= ST_ONE;
          end
        end

        ST_ONE: begin
          if (accept && pop) begin
            // Streaming: the new entry replaces the departing one.
            head_q <= in_payload;
          end else if (accept) begin
            // MEM stalled while EX delivered: park the new entry in SKID.
            skid_q <= in_payload;
            state  <= ST_FULL;
          end else if (pop) begin
            state <= ST_EMPTY;
          end
        end

        ST_FULL: begin
          // in_ready is low here, so only a pop can change anything.
          if (pop) begin
            head_q <= skid_q;
            state  <= ST_ONE;
          end
        end

        default: begin
          state <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule
